// File: rtl/apb_timer_mc.sv
// Multi-channel APB timer: NUM_CH down-counters sharing one prescaler, each with
// periodic/one-shot mode, force reload and a maskable sticky interrupt.
module apb_timer_mc #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int PRE_W  = 8,
  parameter int ADDR_W = 5
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic [NUM_CH-1:0] int_ch,
  output logic              int_timer
);

  localparam logic [31:0]      INTSTAT_A  = 32'(4 * NUM_CH);
  localparam logic [31:0]      PRESCALE_A = 32'(4 * NUM_CH + 1);
  localparam logic [31:0]      MAP_END    = 32'(4 * NUM_CH + 2);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1'b1);
  localparam logic [PRE_W-1:0] PRE_ONE    = PRE_W'(1'b1);

  logic [NUM_CH-1:0]            en_r, int_en_r, oneshot_r, raw_int_r;
  logic [NUM_CH-1:0][CNT_W-1:0] load_r, value_r;
  logic [PRE_W-1:0]             prescale_r, pre_cnt_r;

  logic [NUM_CH-1:0]            en_s, int_en_s, oneshot_s, raw_int_s;
  logic [NUM_CH-1:0][CNT_W-1:0] load_s, value_s;
  logic [PRE_W-1:0]             prescale_s, pre_cnt_s;

  logic [31:0]              addr_s;
  logic                     mapped_s, wr_s, wr_pre_s, tick_s;
  logic [NUM_CH-1:0]        wr_ctrl_s, wr_load_s, wr_cmd_s, force_s, expire_s;
  logic [NUM_CH-1:0][31:0]  chw_s;
  logic [31:0]              rdata_s;

  assign addr_s   = 32'(PADDR);
  assign mapped_s = (addr_s < MAP_END);
  assign wr_s     = PSEL & PENABLE & PWRITE & mapped_s;
  assign wr_pre_s = wr_s & (addr_s == PRESCALE_A);
  assign tick_s   = (pre_cnt_r == prescale_r);

  // Per-channel write strobes decoded from the word address.
  always_comb begin
    wr_ctrl_s = {NUM_CH{1'b0}};
    wr_load_s = {NUM_CH{1'b0}};
    wr_cmd_s  = {NUM_CH{1'b0}};
    for (int c = 0; c < NUM_CH; c++) begin
      wr_ctrl_s[c] = wr_s & (addr_s == 32'(4 * c));
      wr_load_s[c] = wr_s & (addr_s == 32'(4 * c + 1));
      wr_cmd_s[c]  = wr_s & (addr_s == 32'(4 * c + 3));
    end
  end

  // Channel next-state: force reload beats enable-rise reload beats counting.
  always_comb begin
    en_s      = en_r;
    int_en_s  = int_en_r;
    oneshot_s = oneshot_r;
    raw_int_s = raw_int_r;
    load_s    = load_r;
    value_s   = value_r;
    force_s   = {NUM_CH{1'b0}};
    expire_s  = {NUM_CH{1'b0}};
    for (int c = 0; c < NUM_CH; c++) begin
      force_s[c]  = wr_cmd_s[c] & PWDATA[2];
      expire_s[c] = ~force_s[c] & en_r[c] & tick_s & (value_r[c] == {CNT_W{1'b0}});

      if (force_s[c]) begin
        value_s[c] = load_r[c];
      end else if (wr_ctrl_s[c] & PWDATA[0] & ~en_r[c]) begin
        value_s[c] = load_r[c];
      end else if (en_r[c] & tick_s & (value_r[c] != {CNT_W{1'b0}})) begin
        value_s[c] = value_r[c] - CNT_ONE;
      end else if (expire_s[c] & ~oneshot_r[c]) begin
        value_s[c] = load_r[c];
      end else begin
        value_s[c] = value_r[c];
      end

      // A CTRL write in the expiry cycle decides en; the one-shot stop only applies otherwise.
      if (wr_ctrl_s[c]) begin
        en_s[c]      = PWDATA[0];
        int_en_s[c]  = PWDATA[1];
        oneshot_s[c] = PWDATA[2];
      end else if (expire_s[c] & oneshot_r[c]) begin
        en_s[c] = 1'b0;
      end else begin
        en_s[c] = en_r[c];
      end

      if (expire_s[c]) begin
        raw_int_s[c] = 1'b1;
      end else if (wr_cmd_s[c] & PWDATA[0]) begin
        raw_int_s[c] = 1'b0;
      end else begin
        raw_int_s[c] = raw_int_r[c];
      end

      if (wr_load_s[c]) begin
        load_s[c] = PWDATA[CNT_W-1:0];
      end else begin
        load_s[c] = load_r[c];
      end
    end
  end

  // Shared prescaler: a PRESCALE write restarts the count from zero.
  always_comb begin
    if (wr_pre_s) begin
      prescale_s = PWDATA[PRE_W-1:0];
      pre_cnt_s  = {PRE_W{1'b0}};
    end else if (tick_s) begin
      prescale_s = prescale_r;
      pre_cnt_s  = {PRE_W{1'b0}};
    end else begin
      prescale_s = prescale_r;
      pre_cnt_s  = pre_cnt_r + PRE_ONE;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      en_r       <= {NUM_CH{1'b0}};
      int_en_r   <= {NUM_CH{1'b0}};
      oneshot_r  <= {NUM_CH{1'b0}};
      raw_int_r  <= {NUM_CH{1'b0}};
      load_r     <= {NUM_CH{{CNT_W{1'b1}}}};
      value_r    <= {NUM_CH{{CNT_W{1'b1}}}};
      prescale_r <= {PRE_W{1'b0}};
      pre_cnt_r  <= {PRE_W{1'b0}};
    end else begin
      en_r       <= en_s;
      int_en_r   <= int_en_s;
      oneshot_r  <= oneshot_s;
      raw_int_r  <= raw_int_s;
      load_r     <= load_s;
      value_r    <= value_s;
      prescale_r <= prescale_s;
      pre_cnt_r  <= pre_cnt_s;
    end
  end

  // Per-channel read word selected by the low address bits.
  always_comb begin
    chw_s = {NUM_CH{32'h0}};
    for (int c = 0; c < NUM_CH; c++) begin
      case (addr_s[1:0])
        2'd0:    chw_s[c] = 32'({oneshot_r[c], int_en_r[c], en_r[c]});
        2'd1:    chw_s[c] = 32'(load_r[c]);
        2'd2:    chw_s[c] = 32'(value_r[c]);
        2'd3:    chw_s[c] = 32'({raw_int_r[c], int_ch[c]});
        default: chw_s[c] = 32'h0;
      endcase
    end
  end

  // Read data mux; unmapped words and non-read cycles return zero.
  always_comb begin
    rdata_s = 32'h0;
    if (PSEL & ~PWRITE & mapped_s) begin
      if (addr_s == INTSTAT_A) begin
        rdata_s = 32'(int_ch);
      end else if (addr_s == PRESCALE_A) begin
        rdata_s = 32'(prescale_r);
      end else begin
        for (int c = 0; c < NUM_CH; c++) begin
          rdata_s = rdata_s | ((addr_s[31:2] == 30'(c)) ? chw_s[c] : 32'h0);
        end
      end
    end else begin
      rdata_s = 32'h0;
    end
  end

  assign PRDATA    = rdata_s;
  assign PREADY    = 1'b1;
  assign PSLVERR   = PSEL & PENABLE & ~mapped_s;
  assign int_ch    = raw_int_r & int_en_r;
  assign int_timer = |int_ch;

endmodule

// File: tb/tb_apb_timer_mc.sv
// Randomised bench for apb_timer_mc with a behavioural register-map model,
// a per-cycle output compare and a set of directed literal checks.
module tb_apb_timer_mc;
  localparam int N  = 4;
  localparam int CW = 32;
  localparam int PW = 8;
  localparam int AW = 5;
  localparam longint unsigned CMASK = (64'd1 << CW) - 64'd1;
  localparam longint unsigned PMASK = (64'd1 << PW) - 64'd1;

  logic          PCLK = 1'b0;
  logic          PRESET = 1'b1;
  logic          PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [AW-1:0] PADDR = '0;
  logic [31:0]   PWDATA = 32'h0;
  logic [31:0]   PRDATA;
  logic          PREADY, PSLVERR;
  logic [N-1:0]  int_ch;
  logic          int_timer;

  int total = 0;
  int bad   = 0;

  apb_timer_mc #(.NUM_CH(N), .CNT_W(CW), .PRE_W(PW), .ADDR_W(AW)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .int_ch(int_ch), .int_timer(int_timer)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_valid = 1'b0;
  bit m_en[N], m_ie[N], m_os[N], m_raw[N];
  longint unsigned m_load[N], m_val[N];
  longint unsigned m_pre, m_pcnt;

  function automatic logic [N-1:0] m_intvec();
    logic [N-1:0] v;
    v = '0;
    for (int c = 0; c < N; c++) v[c] = m_raw[c] & m_ie[c];
    return v;
  endfunction

  function automatic logic [31:0] m_read(input logic sel, input logic wr, input int a);
    int c;
    if (!sel || wr || a >= 4*N+2) return 32'h0;
    if (a == 4*N) return 32'(m_intvec());
    if (a == 4*N+1) return 32'(m_pre);
    c = a / 4;
    case (a % 4)
      0:       return {29'h0, m_os[c], m_ie[c], m_en[c]};
      1:       return 32'(m_load[c]);
      2:       return 32'(m_val[c]);
      default: return {30'h0, m_raw[c], m_raw[c] & m_ie[c]};
    endcase
  endfunction

  // Advance the model by one clock using the bus inputs present this cycle.
  always @(posedge PCLK) begin
    if (PRESET) begin
      for (int c = 0; c < N; c++) begin
        m_en[c] = 0; m_ie[c] = 0; m_os[c] = 0; m_raw[c] = 0;
        m_load[c] = CMASK; m_val[c] = CMASK;
      end
      m_pre = 0; m_pcnt = 0; m_valid = 1'b1;
    end else if (m_valid) begin
      int a;
      bit wr, tick;
      a    = int'(PADDR);
      wr   = PSEL && PENABLE && PWRITE && (a < 4*N+2);
      tick = (m_pcnt == m_pre);
      for (int c = 0; c < N; c++) begin
        bit mine, frc, rise, xp;
        mine = wr && (a < 4*N) && (a / 4 == c);
        frc  = mine && (a % 4 == 3) && PWDATA[2];
        rise = mine && (a % 4 == 0) && PWDATA[0] && !m_en[c];
        xp   = !frc && m_en[c] && tick && (m_val[c] == 0);
        if (frc || rise) m_val[c] = m_load[c];
        else if (m_en[c] && tick) begin
          if (m_val[c] != 0) m_val[c] = m_val[c] - 1;
          else if (!m_os[c]) m_val[c] = m_load[c];
        end
        if (xp) m_raw[c] = 1;
        else if (mine && (a % 4 == 3) && PWDATA[0]) m_raw[c] = 0;
        if (mine && (a % 4 == 0)) begin
          m_en[c] = PWDATA[0]; m_ie[c] = PWDATA[1]; m_os[c] = PWDATA[2];
        end else if (xp && m_os[c]) m_en[c] = 0;
        if (mine && (a % 4 == 1)) m_load[c] = longint'(PWDATA) & CMASK;
      end
      if (wr && a == 4*N+1) begin
        m_pre = longint'(PWDATA) & PMASK; m_pcnt = 0;
      end else if (tick) m_pcnt = 0;
      else m_pcnt = m_pcnt + 1;
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge PCLK) begin
    if (m_valid) begin
      check("prdata", PRDATA, m_read(PSEL, PWRITE, int'(PADDR)));
      check("pslverr", 32'(PSLVERR), 32'(PSEL && PENABLE && (int'(PADDR) >= 4*N+2)));
      check("int_ch", 32'(int_ch), 32'(m_intvec()));
      check("int_timer", 32'(int_timer), 32'(|m_intvec()));
      check("pready", 32'(PREADY), 32'd1);
    end
  end

  // ---------------- bus tasks ----------------
  task automatic apb_write(input int a, input logic [31:0] d);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a[AW-1:0]; PWDATA = d;
    @(posedge PCLK); #1 PENABLE = 1'b1;
    @(posedge PCLK); #1 PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input int a, output logic [31:0] d, output logic err);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a[AW-1:0];
    @(posedge PCLK); #1 PENABLE = 1'b1;
    @(negedge PCLK); d = PRDATA; err = PSLVERR;
    @(posedge PCLK); #1 PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic peek(input int a);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a[AW-1:0];
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d, want;
    logic err;
    int k;

    repeat (2) @(posedge PCLK);
    #1 PRESET = 1'b0;

    // reset state of every mapped word
    for (int a = 0; a < 4*N+2; a++) begin
      apb_read(a, d, err);
      want = (a < 4*N && (a % 4 == 1 || a % 4 == 2)) ? 32'hFFFF_FFFF : 32'h0;
      check("lit_reset_word", d, want);
      check("lit_reset_err", 32'(err), 32'd0);
    end
    check("lit_reset_int_timer", 32'(int_timer), 32'd0);

    // ch0 periodic, LOAD=3, tick every cycle
    apb_write(1, 32'd3);
    apb_write(0, 32'h3);
    peek(2);
    for (int i = 0; i < 4; i++) begin
      @(negedge PCLK);
      check("lit_ch0_count", PRDATA, 32'(3 - i));
      check("lit_ch0_no_irq", 32'(int_ch[0]), 32'd0);
    end
    @(negedge PCLK);
    check("lit_ch0_reload", PRDATA, 32'd3);
    check("lit_ch0_irq", 32'(int_ch[0]), 32'd1);

    // W1C landing on the expiry edge: set wins
    k = 0;
    do begin @(negedge PCLK); k++; end while (PRDATA != 32'd1 && k < 20);
    check("lit_align_timeout", 32'(k < 20), 32'd1);
    apb_write(3, 32'h1);
    peek(3);
    @(negedge PCLK);
    check("lit_w1c_race", PRDATA, 32'h3);
    apb_write(3, 32'h1);
    peek(3);
    @(negedge PCLK); check("lit_w1c_clear", PRDATA, 32'h0);
    @(negedge PCLK); check("lit_w1c_hold", PRDATA, 32'h0);
    @(negedge PCLK); check("lit_period4", PRDATA, 32'h3);
    apb_write(0, 32'h1);
    peek(3);
    @(negedge PCLK);
    check("lit_mask_stat", PRDATA, 32'h2);
    check("lit_mask_int", 32'(int_ch[0]), 32'd0);

    // ch1 one-shot with prescaler 4
    apb_write(4*N+1, 32'd4);
    apb_write(5, 32'd2);
    apb_write(4, 32'h7);
    repeat (40) @(posedge PCLK);
    #1;
    apb_read(4, d, err); check("lit_os_ctrl", d, 32'h6);
    apb_read(6, d, err); check("lit_os_value", d, 32'h0);
    apb_read(7, d, err); check("lit_os_stat", d, 32'h3);
    apb_write(7, 32'h1);
    repeat (100) @(posedge PCLK);
    #1;
    apb_read(7, d, err); check("lit_os_no_rearm", d, 32'h0);
    apb_read(6, d, err); check("lit_os_value_hold", d, 32'h0);

    // ch2: LOAD write does not disturb count; force reload does
    apb_write(4*N+1, 32'd0);
    apb_write(9, 32'h60);
    apb_write(8, 32'h1);
    peek(10);
    k = 0;
    do begin @(negedge PCLK); k++; end while (PRDATA != 32'h52 && k < 200);
    check("lit_ch2_timeout", 32'(k < 200), 32'd1);
    apb_write(9, 32'h10);
    peek(10);
    @(negedge PCLK); check("lit_ch2_keep", PRDATA, 32'h50);
    @(negedge PCLK); check("lit_ch2_dec", PRDATA, 32'h4F);
    apb_write(11, 32'h4);
    peek(10);
    @(negedge PCLK); check("lit_ch2_force", PRDATA, 32'h10);

    // unmapped accesses
    apb_read(4*N+2, d, err);
    check("lit_unmapped_rd", d, 32'h0);
    check("lit_unmapped_err", 32'(err), 32'd1);
    apb_write(4*N+2, 32'hFFFF_FFFF);
    apb_write(31, 32'hFFFF_FFFF);
    apb_read(4*N+1, d, err); check("lit_unmapped_noeffect", d, 32'h0);
    apb_read(9, d, err);     check("lit_unmapped_load2", d, 32'h10);

    // randomised traffic
    for (int c = 0; c < N; c++) begin
      apb_write(4*c+1, 32'($urandom_range(0, 12)));
      apb_write(4*c, 32'h3);
    end
    for (int i = 0; i < 500; i++) begin
      int a, r;
      logic [31:0] rd;
      logic re;
      if (i == 250) begin
        PRESET = 1'b1;
        @(posedge PCLK); #1 PRESET = 1'b0;
        check("lit_midreset_int", 32'(int_timer), 32'd0);
        apb_read(2, rd, re); check("lit_midreset_value", rd, 32'hFFFF_FFFF);
        for (int c = 0; c < N; c++) begin
          apb_write(4*c+1, 32'($urandom_range(0, 12)));
          apb_write(4*c, 32'h3);
        end
      end
      r = $urandom_range(0, 19);
      a = (r < 18) ? r : $urandom_range(18, 31);
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        if (a == 4*N+1) d = 32'($urandom_range(0, 3));
        else if (a < 4*N && a % 4 == 1) d = 32'($urandom_range(0, 20));
        else if (a < 4*N && a % 4 == 0) d[0] = ($urandom_range(0, 3) != 0);
        apb_write(a, d);
      end else begin
        apb_read(a, rd, re);
      end
      if ($urandom_range(0, 3) == 0) begin
        @(posedge PCLK); #1;
      end
    end

    // reset while counting
    PRESET = 1'b1;
    @(posedge PCLK); #1 PRESET = 1'b0;
    check("lit_final_reset_int", 32'(int_timer), 32'd0);
    for (int a = 0; a < 4*N+2; a++) begin
      apb_read(a, d, err);
      want = (a < 4*N && (a % 4 == 1 || a % 4 == 2)) ? 32'hFFFF_FFFF : 32'h0;
      check("lit_final_reset_word", d, want);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
